dmem_copy_engine: RTL and testbench

- Bus-master initiator for the 32-bit word-addressed data memory. It drives that memory's read/wrtd/address/Din pins and consumes its registered DataOut.
- Performs block copy (memory to memory) or block fill (constant to memory) of up to 2^LEN_W-1 words, started by a one-cycle request from the control unit.
- Sits between the control unit and the data memory port. Its memory outputs connect directly to that port.

---
 rtl/dmem_copy_engine.sv | 148 ++++++++++++++
 tb/tb_dmem_copy_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : dmem_copy_engine
// Brief    : Bus master for the word-addressed data memory; copies or fills a
//            block of words on a single start request.
// Revision : 1.0  initial release
// ============================================================================
module dmem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_read,
  output logic             mem_wrtd,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_fill;
  logic [31:0]      r_addr_q;
  logic [31:0]      r_din_q;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] r_words_done;

  logic             w_last;
  logic             w_read;
  logic             w_wrtd;
  logic [31:0]      w_addr;
  logic [31:0]      w_din;

  assign w_last = (r_rem == LEN_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)     w_next = S_DONE;
          else if (mode)     w_next = S_FILL;
          else               w_next = S_RD;
        end
      end
      S_RD:   w_next = abort ? S_DONE : S_WR;
      S_WR:   w_next = (abort || w_last) ? S_DONE : S_RD;
      S_FILL: w_next = (abort || w_last) ? S_DONE : S_FILL;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address and data hold their last presented value outside active states.
  always_comb begin
    w_read = 1'b0;
    w_wrtd = 1'b0;
    w_addr = r_addr_q;
    w_din  = r_din_q;
    case (r_state)
      S_RD: begin
        w_read = 1'b1;
        w_addr = r_src;
      end
      S_WR: begin
        w_wrtd = 1'b1;
        w_addr = r_dst;
        w_din  = mem_dout;
      end
      S_FILL: begin
        w_wrtd = 1'b1;
        w_addr = r_dst;
        w_din  = r_fill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_fill       <= '0;
      r_addr_q     <= '0;
      r_din_q      <= '0;
      r_rem        <= '0;
      r_words_done <= '0;
    end else begin
      r_state  <= w_next;
      r_addr_q <= w_addr;
      r_din_q  <= w_din;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src        <= src_addr;
            r_dst        <= dst_addr;
            r_rem        <= len;
            r_fill       <= fill_data;
            r_words_done <= '0;
          end
        end
        S_WR: begin
          r_words_done <= r_words_done + LEN_W'(1);
          r_src        <= r_src + 32'd1;
          r_dst        <= r_dst + 32'd1;
          r_rem        <= r_rem - LEN_W'(1);
        end
        S_FILL: begin
          r_words_done <= r_words_done + LEN_W'(1);
          r_dst        <= r_dst + 32'd1;
          r_rem        <= r_rem - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_RD) || (r_state == S_WR) || (r_state == S_FILL);
  assign done        = (r_state == S_DONE);
  assign words_done  = r_words_done;
  assign mem_read    = w_read;
  assign mem_wrtd    = w_wrtd;
  assign mem_address = w_addr;
  assign mem_din     = w_din;

endmodule
`default_nettype wire

// File: tb/tb_dmem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_copy_engine
// Brief    : Randomized bench for dmem_copy_engine with a word-level memory
//            image model and a registered-read memory behind the DUT.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_copy_engine;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic [31:0]      fill_data;
  logic             abort;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] words_done;
  logic             mem_read;
  logic             mem_wrtd;
  logic [31:0]      mem_address;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout;

  logic             bd_init;
  logic             bd_we;
  logic [15:0]      bd_addr;
  logic [31:0]      bd_data;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dmem_copy_engine #(.LEN_W(LEN_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_data  (fill_data),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .mem_read   (mem_read),
    .mem_wrtd   (mem_wrtd),
    .mem_address(mem_address),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Data memory: 16-bit decode, registered DataOut, plus a backdoor port.
  always @(posedge clk) begin
    if (bd_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
    end else begin
      if (bd_we)    mem[bd_addr] <= bd_data;
      if (mem_wrtd) mem[mem_address[15:0]] <= mem_din;
    end
    if (mem_read) mem_dout <= mem[mem_address[15:0]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic mem_compare(input string tag);
    int diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk(tag, 64'(diffs), 64'd0);
  endtask

  // One transfer; ab>0 raises abort during the ab-th write.
  task automatic xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                      input int n, input logic [31:0] f, input int ab, input bit hold);
    int k;
    int c;
    int rd;
    int wr;
    k = (ab > 0 && ab <= n) ? ab : n;
    for (int j = 0; j < k; j++) begin
      if (m) ref_mem[16'(d + 32'(j))] = f;
      else   ref_mem[16'(d + 32'(j))] = ref_mem[16'(s + 32'(j))];
    end
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = LEN_W'(n); fill_data = f;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    c = 1; rd = 0; wr = 0;
    while (!done && c <= 2 * n + 5) begin
      chk("busy", busy, 1);
      chk("excl", mem_read & mem_wrtd, 0);
      if (mem_read) begin
        chk("rd_addr", mem_address, s + 32'(rd));
        if (m) chk("fill_rd", 1, 0);
        rd++;
      end
      if (mem_wrtd) begin
        chk("wr_addr", mem_address, d + 32'(wr));
        wr++;
        if (wr == ab) abort = 1'b1;
      end
      @(posedge clk); #1;
      abort = 1'b0;
      c++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("latency", 64'(c), m ? 64'(k + 1) : 64'(2 * k + 1));
    chk("busy_done", busy, 0);
    chk("strobe_done", {mem_read, mem_wrtd}, 0);
    chk("writes", 64'(wr), 64'(k));
    chk("words_done", words_done, 64'(k));
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("wd_hold", words_done, 64'(k));
    mem_compare("mem");
  endtask

  initial begin
    logic        m;
    logic [31:0] s, d;
    int          n, ab;

    rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_data = '0; abort = 1'b0;
    bd_init = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    @(posedge clk); #1;
    bd_init = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wd", words_done, 0);
    chk("rst_strobes", {mem_read, mem_wrtd}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_din, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed copy, fill, empty, held start, abort and wrap cases
    poke(16'h10, 32'hA0A0_0000); poke(16'h11, 32'hA1A1_1111);
    poke(16'h12, 32'hA2A2_2222); poke(16'h13, 32'hA3A3_3333);
    xfer(1'b0, 32'h10, 32'h40, 4, 32'h0, 0, 1'b0);
    chk("copy_w0", mem[16'h40], 32'hA0A0_0000);
    chk("copy_w3", mem[16'h43], 32'hA3A3_3333);
    xfer(1'b1, 32'h0, 32'h100, 3, 32'hDEADBEEF, 0, 1'b0);
    chk("fill_w2", mem[16'h102], 32'hDEADBEEF);
    xfer(1'b0, 32'h500, 32'h600, 0, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h700, 32'h800, 3, 32'h0, 0, 1'b1);
    xfer(1'b0, 32'h900, 32'hA00, 8, 32'h0, 3, 1'b0);
    poke(16'hFFFE, 32'h1234_5678);
    xfer(1'b0, 32'hFFFE, 32'hFFFF, 2, 32'h0, 0, 1'b0);
    chk("wrap_w0", mem[16'h0000], 32'h1234_5678);

    for (int t = 0; t < 24; t++) begin
      m = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 65535));
      d = ($urandom_range(0, 1) == 0) ? s + 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      n = $urandom_range(0, 20);
      ab = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n) : 0;
      xfer(m, s, d, n, $urandom, ab, 1'($urandom_range(0, 1)));
    end

    // Reset during an active copy
    start = 1'b1; mode = 1'b0; src_addr = 32'h200; dst_addr = 32'h300; len = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_wd", words_done, 0);
    chk("mrst_strobes", {mem_read, mem_wrtd}, 0);
    chk("mrst_addr", mem_address, 0);
    chk("mrst_din", mem_din, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_wrtd", mem_wrtd, 0);
      chk("post_rst_busy", busy, 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    xfer(1'b1, 32'h0, 32'h300, 2, 32'hCAFE_F00D, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
